// File: rtl/cart_bus_responder.sv
// cart_bus_responder
// Cartridge-side responder for a console CPU bus clocked by the console's m2
// (phi2). m2 is synchronized into the master_clock domain and a three-state
// FSM tracks each bus cycle. Writes into ROM space are committed into a
// 4-bit PRG bank register. PRG ROM decode and output enables are combinational
// from the raw pins. A watchdog timer flags a lost m2 and aborts a stalled
// cycle.
//
// Optional feature: define BUS_CONFLICT_EN to AND the written value with the
// ROM byte driven during the same cycle (bus-conflict emulation). When the
// macro is undefined, the committed bank is the CPU data alone and rom_data
// is ignored.

module cart_bus_responder #(
   parameter int M2_TIMEOUT = 63
) (
   input  logic        master_clock,
   input  logic        reset,
   input  logic        m2,
   input  logic        romsel,
   input  logic        cpu_rw,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic [7:0]  rom_data,
   output logic [17:0] prg_addr,
   output logic        rom_oe_n,
   output logic        cpu_data_oe,
   output logic [3:0]  prg_bank,
   output logic        wr_strobe,
   output logic [7:0]  write_count,
   output logic        m2_lost
);

   typedef enum logic [1:0] {
      WAIT_HIGH,
      ACTIVE,
      COMMIT
   } state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(M2_TIMEOUT);

   // m2 synchronizer and edge history
   logic        r_m2_sync1;
   logic        r_m2_sync2;
   logic        r_m2_hist;
   logic        w_m2_rise;
   logic        w_m2_fall;
   logic        w_m2_edge;

   // m2 watchdog
   logic [7:0]  r_timer;
   logic        w_timeout;

   // bus cycle FSM and registered outputs
   state_t      r_state;
   logic        r_romsel;
   logic        r_rw;
   logic [14:0] r_addr;
   logic [7:0]  r_data;
`ifdef BUS_CONFLICT_EN
   logic [7:0]  r_rom_data;
`endif
   logic [3:0]  r_prg_bank;
   logic        r_wr_strobe;
   logic [7:0]  r_write_count;
   logic        r_m2_lost;
   logic [3:0]  w_new_bank;
   logic        w_unused;

   // Two-flop synchronizer for the asynchronous m2, plus one history flop so
   // edges are judged only between fully synchronized samples.
   always_ff @(posedge master_clock or posedge reset) begin
      // NOTE: every register uses <= so all flops update together from
      // pre-edge values; a blocking = here would collapse the sync chain.
      if (reset) begin
         r_m2_sync1 <= 1'b0;
         r_m2_sync2 <= 1'b0;
         r_m2_hist  <= 1'b0;
      end else begin
         r_m2_sync1 <= m2;
         r_m2_sync2 <= r_m2_sync1;
         r_m2_hist  <= r_m2_sync2;
      end
   end

   assign w_m2_rise = r_m2_sync2 & ~r_m2_hist;
   assign w_m2_fall = ~r_m2_sync2 & r_m2_hist;
   assign w_m2_edge = w_m2_rise | w_m2_fall;

   // Timeout fires on the clock the timer reaches M2_TIMEOUT and keeps firing
   // while saturated; an edge in the same clock always takes priority.
   assign w_timeout = ~w_m2_edge && (r_timer >= (TIMEOUT_VAL - 8'd1));

   // Edge timer: cleared by any synced m2 edge, otherwise counts up and
   // saturates at M2_TIMEOUT.
   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         r_timer <= 8'd0;
      end else if (w_m2_edge) begin
         r_timer <= 8'd0;
      end else if (r_timer != TIMEOUT_VAL) begin
         r_timer <= r_timer + 8'd1;
      end
   end

`ifdef BUS_CONFLICT_EN
   // The ROM drives the bus during the write too, so the CPU sees the AND.
   assign w_new_bank = r_data[3:0] & r_rom_data[3:0];
   assign w_unused   = ^{r_addr, r_data[7:4], r_rom_data[7:4]};
`else
   assign w_new_bank = r_data[3:0];
   assign w_unused   = ^{r_addr, r_data[7:4], rom_data};
`endif

   // Bus cycle FSM: capture the cycle on m2 rise, track data while m2 is
   // high, commit ROM-space writes after m2 falls.
   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         r_state       <= WAIT_HIGH;
         r_romsel      <= 1'b1;
         r_rw          <= 1'b1;
         r_addr        <= 15'd0;
         r_data        <= 8'd0;
`ifdef BUS_CONFLICT_EN
         r_rom_data    <= 8'd0;
`endif
         r_prg_bank    <= 4'd0;
         r_wr_strobe   <= 1'b0;
         r_write_count <= 8'd0;
         r_m2_lost     <= 1'b0;
      end else begin
         r_wr_strobe <= 1'b0;
         if (w_timeout) begin
            r_m2_lost <= 1'b1;
         end

         case (r_state)
            WAIT_HIGH: begin
               if (w_m2_rise) begin
                  r_romsel  <= romsel;
                  r_rw      <= cpu_rw;
                  r_addr    <= cpu_addr;
                  r_m2_lost <= 1'b0;
                  r_state   <= ACTIVE;
               end
            end

            ACTIVE: begin
               r_data <= cpu_data_in;
`ifdef BUS_CONFLICT_EN
               r_rom_data <= rom_data;
`endif
               if (w_m2_rise) begin
                  // Falling edge was missed: drop the old cycle, start anew.
                  r_romsel  <= romsel;
                  r_rw      <= cpu_rw;
                  r_addr    <= cpu_addr;
                  r_m2_lost <= 1'b0;
               end else if (w_m2_fall) begin
                  r_state <= (!r_romsel && !r_rw) ? COMMIT : WAIT_HIGH;
               end else if (w_timeout) begin
                  r_state <= WAIT_HIGH;
               end
            end

            COMMIT: begin
               r_prg_bank    <= w_new_bank;
               r_wr_strobe   <= 1'b1;
               r_write_count <= r_write_count + 8'd1;
               r_state       <= WAIT_HIGH;
            end

            default: begin
               r_state <= WAIT_HIGH;
            end
         endcase
      end
   end

   // Read decode works straight off the pins so ROM data meets CPU timing.
   assign rom_oe_n    = ~(~romsel & cpu_rw & m2);
   assign cpu_data_oe = ~romsel & cpu_rw & m2;
   assign prg_addr    = cpu_addr[14] ? {4'hF, cpu_addr[13:0]}
                                     : {r_prg_bank, cpu_addr[13:0]};

   assign prg_bank    = r_prg_bank;
   assign wr_strobe   = r_wr_strobe;
   assign write_count = r_write_count;
   assign m2_lost     = r_m2_lost;

endmodule

// File: tb/tb_cart_bus_responder.sv
// Directed testbench for cart_bus_responder (default M2_TIMEOUT = 63).
// Inputs change on the falling clock edge; registered outputs are sampled on
// the falling edge, combinational outputs #1 after their inputs change.

module tb_cart_bus_responder;

   logic        master_clock;
   logic        reset;
   logic        m2;
   logic        romsel;
   logic        cpu_rw;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_data_in;
   logic [7:0]  rom_data;
   logic [17:0] prg_addr;
   logic        rom_oe_n;
   logic        cpu_data_oe;
   logic [3:0]  prg_bank;
   logic        wr_strobe;
   logic [7:0]  write_count;
   logic        m2_lost;

   int pass_count  = 0;
   int check_count = 0;
   int strobe_count = 0;

   cart_bus_responder #(.M2_TIMEOUT(63)) dut (
      .master_clock (master_clock),
      .reset        (reset),
      .m2           (m2),
      .romsel       (romsel),
      .cpu_rw       (cpu_rw),
      .cpu_addr     (cpu_addr),
      .cpu_data_in  (cpu_data_in),
      .rom_data     (rom_data),
      .prg_addr     (prg_addr),
      .rom_oe_n     (rom_oe_n),
      .cpu_data_oe  (cpu_data_oe),
      .prg_bank     (prg_bank),
      .wr_strobe    (wr_strobe),
      .write_count  (write_count),
      .m2_lost      (m2_lost)
   );

   initial master_clock = 1'b0;
   always #5 master_clock = ~master_clock;

   // Count strobe pulses, sampled mid-cycle.
   always @(negedge master_clock) begin
      if (wr_strobe) strobe_count++;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge master_clock);
   endtask

   task automatic bus_cycle(input logic [14:0] addr, input logic rw, input logic rs,
                            input logic [7:0] d, input logic [7:0] rd,
                            input int hi, input int lo);
      cpu_addr    = addr;
      cpu_rw      = rw;
      romsel      = rs;
      cpu_data_in = d;
      rom_data    = rd;
      m2          = 1'b1;
      wait_clks(hi);
      m2 = 1'b0;
      wait_clks(lo);
      romsel = 1'b1;
      cpu_rw = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      wait_clks(3);
      check_count++;
      if (prg_bank !== 4'd0) $display("FAIL reset_bank: got %0h expected 0", prg_bank);
      else pass_count++;
      check_count++;
      if (write_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", write_count);
      else pass_count++;
      check_count++;
      if (wr_strobe !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", wr_strobe);
      else pass_count++;
      check_count++;
      if (m2_lost !== 1'b0) $display("FAIL reset_m2_lost: got %b expected 0", m2_lost);
      else pass_count++;
      check_count++;
      if (rom_oe_n !== 1'b1 || cpu_data_oe !== 1'b0)
         $display("FAIL idle_oe: got oe_n=%b oe=%b expected oe_n=1 oe=0", rom_oe_n, cpu_data_oe);
      else pass_count++;
      reset = 1'b0;
      wait_clks(2);
   endtask

   task automatic test_write;
      int s0;
      s0 = strobe_count;
      bus_cycle(15'h0000, 1'b0, 1'b0, 8'h05, 8'hFF, 8, 8);
      check_count++;
      if (prg_bank !== 4'h5) $display("FAIL write_bank: got %0h expected 5", prg_bank);
      else pass_count++;
      check_count++;
      if (strobe_count - s0 !== 1) $display("FAIL write_strobe: got %0d pulses expected 1", strobe_count - s0);
      else pass_count++;
      check_count++;
      if (write_count !== 8'd1) $display("FAIL write_count: got %0d expected 1", write_count);
      else pass_count++;
   endtask

   task automatic test_read_decode;
      bus_cycle(15'h0000, 1'b0, 1'b0, 8'h03, 8'hFF, 8, 8);
      cpu_addr = 15'h1234;
      cpu_rw   = 1'b1;
      romsel   = 1'b0;
      m2       = 1'b1;
      #1;
      check_count++;
      if (rom_oe_n !== 1'b0 || cpu_data_oe !== 1'b1)
         $display("FAIL read_oe: got oe_n=%b oe=%b expected oe_n=0 oe=1", rom_oe_n, cpu_data_oe);
      else pass_count++;
      check_count++;
      if (prg_addr !== 18'h0D234) $display("FAIL read_addr_low: got %05h expected 0D234", prg_addr);
      else pass_count++;
      cpu_addr = 15'h4000;
      #1;
      check_count++;
      if (prg_addr !== 18'h3C000) $display("FAIL read_addr_fixed: got %05h expected 3C000", prg_addr);
      else pass_count++;
      romsel = 1'b1;
      #1;
      check_count++;
      if (rom_oe_n !== 1'b1 || cpu_data_oe !== 1'b0)
         $display("FAIL read_oe_romsel_high: got oe_n=%b oe=%b expected oe_n=1 oe=0", rom_oe_n, cpu_data_oe);
      else pass_count++;
      romsel = 1'b0;
      wait_clks(7);
      m2 = 1'b0;
      #1;
      check_count++;
      if (rom_oe_n !== 1'b1 || cpu_data_oe !== 1'b0)
         $display("FAIL read_oe_m2_low: got oe_n=%b oe=%b expected oe_n=1 oe=0", rom_oe_n, cpu_data_oe);
      else pass_count++;
      wait_clks(8);
      romsel = 1'b1;
      check_count++;
      if (prg_bank !== 4'h3 || write_count !== 8'd2)
         $display("FAIL read_no_commit: got bank=%0h count=%0d expected bank=3 count=2", prg_bank, write_count);
      else pass_count++;
   endtask

   task automatic test_romsel_write;
      int s0;
      s0 = strobe_count;
      bus_cycle(15'h0000, 1'b0, 1'b1, 8'h07, 8'hFF, 8, 8);
      check_count++;
      if (prg_bank !== 4'h3) $display("FAIL romsel_bank: got %0h expected 3", prg_bank);
      else pass_count++;
      check_count++;
      if (write_count !== 8'd2) $display("FAIL romsel_count: got %0d expected 2", write_count);
      else pass_count++;
      check_count++;
      if (strobe_count != s0) $display("FAIL romsel_strobe: got %0d pulses expected 0", strobe_count - s0);
      else pass_count++;
   endtask

   task automatic test_bus_conflict;
      logic [3:0] exp_bank;
`ifdef BUS_CONFLICT_EN
      exp_bank = 4'h6;
`else
      exp_bank = 4'hF;
`endif
      bus_cycle(15'h0000, 1'b0, 1'b0, 8'h0F, 8'h06, 8, 8);
      check_count++;
      if (prg_bank !== exp_bank) $display("FAIL conflict_bank: got %0h expected %0h", prg_bank, exp_bank);
      else pass_count++;
      check_count++;
      if (write_count !== 8'd3) $display("FAIL conflict_count: got %0d expected 3", write_count);
      else pass_count++;
   endtask

   task automatic test_timeout;
      int s0;
      logic [3:0] bank0;
      s0    = strobe_count;
      bank0 = prg_bank;
      cpu_addr    = 15'h0000;
      cpu_rw      = 1'b0;
      romsel      = 1'b0;
      cpu_data_in = 8'h0A;
      rom_data    = 8'hFF;
      m2          = 1'b1;
      wait_clks(60);
      check_count++;
      if (m2_lost !== 1'b0) $display("FAIL timeout_early: got m2_lost=%b expected 0", m2_lost);
      else pass_count++;
      wait_clks(10);
      check_count++;
      if (m2_lost !== 1'b1) $display("FAIL timeout_set: got m2_lost=%b expected 1", m2_lost);
      else pass_count++;
      m2 = 1'b0;
      wait_clks(8);
      romsel = 1'b1;
      cpu_rw = 1'b1;
      check_count++;
      if (strobe_count != s0 || write_count !== 8'd3 || prg_bank !== bank0)
         $display("FAIL timeout_no_commit: got pulses=%0d count=%0d bank=%0h expected 0/3/%0h",
                  strobe_count - s0, write_count, prg_bank, bank0);
      else pass_count++;
      check_count++;
      if (m2_lost !== 1'b1) $display("FAIL timeout_sticky: got m2_lost=%b expected 1", m2_lost);
      else pass_count++;
      bus_cycle(15'h1000, 1'b1, 1'b0, 8'h00, 8'hFF, 8, 8);
      check_count++;
      if (m2_lost !== 1'b0) $display("FAIL timeout_clear: got m2_lost=%b expected 0", m2_lost);
      else pass_count++;
   endtask

   task automatic test_reset_mid_cycle;
      int s0;
      s0 = strobe_count;
      cpu_addr    = 15'h0000;
      cpu_rw      = 1'b0;
      romsel      = 1'b0;
      cpu_data_in = 8'h09;
      m2          = 1'b1;
      wait_clks(5);
      reset = 1'b1;
      wait_clks(1);
      m2 = 1'b0;
      wait_clks(2);
      check_count++;
      if (prg_bank !== 4'd0 || write_count !== 8'd0 || wr_strobe !== 1'b0 || m2_lost !== 1'b0)
         $display("FAIL midreset_state: got bank=%0h count=%0d strobe=%b lost=%b expected all 0",
                  prg_bank, write_count, wr_strobe, m2_lost);
      else pass_count++;
      reset = 1'b0;
      wait_clks(10);
      romsel = 1'b1;
      cpu_rw = 1'b1;
      check_count++;
      if (strobe_count != s0) $display("FAIL midreset_strobe: got %0d pulses expected 0", strobe_count - s0);
      else pass_count++;
      check_count++;
      if (write_count !== 8'd0 || prg_bank !== 4'd0)
         $display("FAIL midreset_no_commit: got count=%0d bank=%0h expected 0/0", write_count, prg_bank);
      else pass_count++;
   endtask

   task automatic test_wrap;
      int s0;
      s0 = strobe_count;
      for (int i = 0; i < 255; i++) begin
         bus_cycle(15'h0000, 1'b0, 1'b0, 8'(i), 8'hFF, 4, 5);
      end
      check_count++;
      if (write_count !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", write_count);
      else pass_count++;
      check_count++;
      if (prg_bank !== 4'hE) $display("FAIL wrap_bank: got %0h expected e", prg_bank);
      else pass_count++;
      bus_cycle(15'h0000, 1'b0, 1'b0, 8'h01, 8'hFF, 4, 5);
      check_count++;
      if (write_count !== 8'd0) $display("FAIL wrap_zero: got %0d expected 0", write_count);
      else pass_count++;
      check_count++;
      if (strobe_count - s0 != 256) $display("FAIL wrap_strobes: got %0d expected 256", strobe_count - s0);
      else pass_count++;
   endtask

   initial begin
      reset       = 1'b1;
      m2          = 1'b0;
      romsel      = 1'b1;
      cpu_rw      = 1'b1;
      cpu_addr    = 15'h0000;
      cpu_data_in = 8'h00;
      rom_data    = 8'hFF;

      test_reset;
      test_write;
      test_read_decode;
      test_romsel_write;
      test_bus_conflict;
      test_timeout;
      test_reset_mid_cycle;
      test_wrap;

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/cart_bus_responder.md
CART_BUS_RESPONDER -- requirements
Module: cart_bus_responder

Interface
REQ-001 Parameter: M2_TIMEOUT, default 63, number of master_clock cycles without an m2 edge before the cycle is declared lost (range 2..255).
REQ-002 Port: master_clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: m2  in  1  console CPU phi2, asynchronous to master_clock.
REQ-005 Port: romsel  in  1  /ROMSEL from console, active-low.
REQ-006 Port: cpu_rw  in  1  CPU R/W, 1 = read.
REQ-007 Port: cpu_addr  in  15  CPU A14..A0.
REQ-008 Port: cpu_data_in  in  8  CPU data bus sampled value.
REQ-009 Port: rom_data  in  8  PRG ROM output, used for bus-conflict resolution.
REQ-010 Port: prg_addr  out  18  PRG ROM address.
REQ-011 Port: rom_oe_n  out  1  PRG ROM output enable, active-low.
REQ-012 Port: cpu_data_oe  out  1  enables cartridge data drivers toward the console.
REQ-013 Port: prg_bank  out  4  switchable bank register.
REQ-014 Port: wr_strobe  out  1  one-clock pulse per committed mapper write.
REQ-015 Port: write_count  out  8  committed mapper writes, wraps.
REQ-016 Port: m2_lost  out  1  sticky m2 timeout flag.

Function
REQ-017 m2 SHALL pass through a two-flop synchronizer; edges SHALL be detected between the second flop and a third history flop; edge latency 2–3 clocks.
REQ-018 rom_oe_n and cpu_data_oe SHALL be combinational from raw pins: active iff !romsel && cpu_rw && m2.
REQ-019 prg_addr SHALL be {prg_bank, cpu_addr[13:0]} when cpu_addr[14]=0 and {4'hF, cpu_addr[13:0]} when cpu_addr[14]=1, combinationally.
REQ-020 FSM states SHALL be WAIT_HIGH, ACTIVE, COMMIT.
REQ-021 WAIT_HIGH: on synced m2 rising edge, latch romsel, cpu_rw, cpu_addr into cycle registers, clear m2_lost, go ACTIVE.
REQ-022 ACTIVE: every clock latch cpu_data_in; on synced m2 falling edge go COMMIT if latched romsel=0 and cpu_rw=0, else WAIT_HIGH.
REQ-023 COMMIT (one clock): load prg_bank from the last latched data [3:0], pulse wr_strobe, increment write_count (255 wraps to 0), go WAIT_HIGH.
REQ-024 Writes with latched romsel=1 SHALL NOT alter prg_bank, wr_strobe or write_count.
REQ-025 An edge timer SHALL clear on every synced m2 edge and otherwise increment, saturating at M2_TIMEOUT.
REQ-026 When the timer reaches M2_TIMEOUT, m2_lost SHALL set and a cycle in ACTIVE SHALL abort to WAIT_HIGH without commit.
REQ-027 An m2 edge and timeout in the same clock: the edge SHALL win; the timer clears, m2_lost unchanged.
REQ-028 A rising edge detected while in ACTIVE (missed falling edge) SHALL abort the old cycle and start a new one.

Reset
REQ-029 While reset is high: state WAIT_HIGH, prg_bank 0, write_count 0, wr_strobe 0, m2_lost 0, timer 0, synchronizer flops 0.
REQ-030 Reset asserted mid-cycle SHALL discard the cycle with no commit; after release the first recognised edge SHALL be a rising edge.

Configuration
REQ-031 Macro BUS_CONFLICT_EN defined: COMMIT loads prg_bank from (latched data & rom_data sampled in the same clock as latched data)[3:0].
REQ-032 Macro BUS_CONFLICT_EN undefined: COMMIT loads latched cpu_data_in[3:0] only; rom_data unused.

Verification
REQ-033 Write $8000=0x05, romsel=0, rw=0, m2 high 8 clocks, low 8 -> prg_bank=5, one wr_strobe, write_count=1.
REQ-034 Read $9234 with prg_bank=3, m2 high, romsel=0 -> rom_oe_n=0, cpu_data_oe=1, prg_addr=0x0D234; read $C000 -> prg_addr=0x3C000.
REQ-035 Write 0x07 with romsel=1 -> prg_bank, write_count unchanged, no wr_strobe.
REQ-036 m2 held high 70 clocks during write (M2_TIMEOUT=63) -> m2_lost=1 at clock 63, no commit; next rising edge -> m2_lost=0.
REQ-037 With BUS_CONFLICT_EN: write 0x0F while rom_data=0x06 -> prg_bank=6; without macro -> prg_bank=0xF.
REQ-038 256 committed writes -> write_count wraps to 0; reset pulsed mid-ACTIVE -> all outputs per REQ-029, no wr_strobe.
